pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 12 +
 rtl/sat_cnt.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 159 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: state encoding and register-number width.
package pipe_ctrl_pkg;

    localparam int unsigned RegW = 3;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StHalt    = 2'd2
    } state_e;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous enable and asynchronous active-low clear.
module sat_cnt #(
    parameter int unsigned Width = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [Width-1:0] cnt
);

    logic [Width-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_q <= cnt_q + Width'(1);
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, memory-wait stalls with timeout,
// exception halt, and a saturating stall-cycle counter.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RegW-1:0]  id_rs,
    input  logic [RegW-1:0]  id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic [RegW-1:0]  ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic             mem_en,
    input  logic             mem_busy,
    input  logic             br_taken,
    input  logic             excp,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             idex_stall,
    output logic             exmem_stall,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_flush,
    output logic             halted,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);

    state_e           state_q, state_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic             timeout_q, timeout_d;
    logic             load_use;
    logic             wait_at_limit;

    assign load_use = ex_mem_read & ex_reg_write &
                      ((id_rs_used & (id_rs == ex_rd)) | (id_rt_used & (id_rt == ex_rd)));
    assign wait_at_limit = (wait_q == WaitW'(MEM_TIMEOUT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StRun;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        case (state_q)
            StRun: begin
                if (excp) begin
                    state_d = StHalt;
                end else if (mem_en && mem_busy) begin
                    state_d = StMemWait;
                    wait_d  = WaitW'(1);
                end
            end
            StMemWait: begin
                if (excp) begin
                    state_d = StHalt;
                end else if (mem_busy) begin
                    if (wait_at_limit) begin
                        state_d   = StHalt;
                        timeout_d = 1'b1;
                    end else begin
                        wait_d = wait_q + WaitW'(1);
                    end
                end else begin
                    state_d = StRun;
                end
            end
            StHalt:  state_d = StHalt;
            default: state_d = StRun;
        endcase
    end

    // Outputs are held low while reset is asserted, independent of the inputs.
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_stall  = 1'b0;
        exmem_stall = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;
        if (rst) begin
            case (state_q)
                StRun: begin
                    if (excp) begin
                        exmem_stall = 1'b1;
                        memwb_flush = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                    end else if (mem_en && mem_busy) begin
                        pc_stall    = 1'b1;
                        ifid_stall  = 1'b1;
                        idex_stall  = 1'b1;
                        exmem_stall = 1'b1;
                        memwb_flush = 1'b1;
                    end else if (br_taken) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (load_use) begin
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        idex_flush = 1'b1;
                    end
                end
                StMemWait: begin
                    if (excp) begin
                        exmem_stall = 1'b1;
                        memwb_flush = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                    end else if (mem_busy) begin
                        pc_stall    = 1'b1;
                        ifid_stall  = 1'b1;
                        idex_stall  = 1'b1;
                        exmem_stall = 1'b1;
                        memwb_flush = 1'b1;
                    end
                end
                StHalt: begin
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    idex_stall  = 1'b1;
                    exmem_stall = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign halted      = (state_q == StHalt);
    assign timeout_err = timeout_q;

    sat_cnt #(
        .Width (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst),
        .en    (pc_stall),
        .cnt   (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: single-cycle hazard vector table plus multi-cycle sequences.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] id_rs, id_rt, ex_rd;
    logic       id_rs_used, id_rt_used, ex_reg_write, ex_mem_read;
    logic       mem_en, mem_busy, br_taken, excp;

    logic        pc_stall, ifid_stall, idex_stall, exmem_stall;
    logic        ifid_flush, idex_flush, memwb_flush, halted, timeout_err;
    logic [15:0] stall_cnt;
    logic [6:0]  outs;

    // Narrow-counter instance shares stimulus; only its stall_cnt is examined (saturation).
    logic       s_pc_stall, s_ifid_stall, s_idex_stall, s_exmem_stall;
    logic       s_ifid_flush, s_idex_flush, s_memwb_flush, s_halted, s_timeout_err;
    logic [2:0] s_stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (15),
        .CNT_W       (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rs_used   (id_rs_used),
        .id_rt_used   (id_rt_used),
        .ex_rd        (ex_rd),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .mem_en       (mem_en),
        .mem_busy     (mem_busy),
        .br_taken     (br_taken),
        .excp         (excp),
        .pc_stall     (pc_stall),
        .ifid_stall   (ifid_stall),
        .idex_stall   (idex_stall),
        .exmem_stall  (exmem_stall),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .memwb_flush  (memwb_flush),
        .halted       (halted),
        .timeout_err  (timeout_err),
        .stall_cnt    (stall_cnt)
    );

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (15),
        .CNT_W       (3)
    ) dut_small (
        .clk          (clk),
        .rst          (rst),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rs_used   (id_rs_used),
        .id_rt_used   (id_rt_used),
        .ex_rd        (ex_rd),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .mem_en       (mem_en),
        .mem_busy     (mem_busy),
        .br_taken     (br_taken),
        .excp         (excp),
        .pc_stall     (s_pc_stall),
        .ifid_stall   (s_ifid_stall),
        .idex_stall   (s_idex_stall),
        .exmem_stall  (s_exmem_stall),
        .ifid_flush   (s_ifid_flush),
        .idex_flush   (s_idex_flush),
        .memwb_flush  (s_memwb_flush),
        .halted       (s_halted),
        .timeout_err  (s_timeout_err),
        .stall_cnt    (s_stall_cnt)
    );

    assign outs = {pc_stall, ifid_stall, idex_stall, exmem_stall,
                   ifid_flush, idex_flush, memwb_flush};

    // Expected-output encodings: {pc, ifid_s, idex_s, exmem_s, ifid_f, idex_f, memwb_f}
    localparam logic [6:0] ONone   = 7'b0000000;
    localparam logic [6:0] OLoad   = 7'b1100010;
    localparam logic [6:0] OBranch = 7'b0000110;
    localparam logic [6:0] OMem    = 7'b1111001;
    localparam logic [6:0] OHalt   = 7'b1111000;
    localparam logic [6:0] OExcp   = 7'b0001111;

    typedef struct {
        logic [2:0] rs;
        logic [2:0] rt;
        logic       rs_used;
        logic       rt_used;
        logic [2:0] rd;
        logic       reg_write;
        logic       mem_read;
        logic       men;
        logic       busy;
        logic       br;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_cnt(input string name);
        int sat;
        sat = (exp_cnt > 7) ? 7 : exp_cnt;
        check({name, "_cnt"}, 32'(stall_cnt), 32'(exp_cnt));
        check({name, "_cnt3"}, 32'(s_stall_cnt), 32'(sat));
    endtask

    task automatic idle();
        id_rs = 3'd0; id_rt = 3'd0; id_rs_used = 1'b0; id_rt_used = 1'b0;
        ex_rd = 3'd0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
        mem_en = 1'b0; mem_busy = 1'b0; br_taken = 1'b0; excp = 1'b0;
    endtask

    // Called at a negedge with inputs already driven: check outputs, advance one cycle.
    task automatic step(input string name, input logic [6:0] exp);
        #2;
        check(name, 32'(outs), 32'(exp));
        @(posedge clk);
        if (exp[6]) exp_cnt++;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ONone};
        vecs[1]  = '{3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, OLoad};
        vecs[2]  = '{3'd0, 3'd5, 1'b0, 1'b1, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, OLoad};
        vecs[3]  = '{3'd3, 3'd3, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ONone};
        vecs[4]  = '{3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ONone};
        vecs[5]  = '{3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ONone};
        vecs[6]  = '{3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, OBranch};
        vecs[7]  = '{3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, OBranch};
        vecs[8]  = '{3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ONone};
        vecs[9]  = '{3'd2, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ONone};
        vecs[10] = '{3'd0, 3'd7, 1'b0, 1'b1, 3'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, OLoad};

        // Reset state
        rst = 1'b0;
        idle();
        #3;
        check("rst_outs", 32'(outs), 32'(ONone));
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);
        check_cnt("rst");
        @(negedge clk);
        rst = 1'b1;
        step("idle_after_rst", ONone);

        // Single-cycle hazard table
        for (int i = 0; i < 11; i++) begin
            id_rs = vecs[i].rs; id_rt = vecs[i].rt;
            id_rs_used = vecs[i].rs_used; id_rt_used = vecs[i].rt_used;
            ex_rd = vecs[i].rd; ex_reg_write = vecs[i].reg_write;
            ex_mem_read = vecs[i].mem_read; mem_en = vecs[i].men;
            mem_busy = vecs[i].busy; br_taken = vecs[i].br; excp = 1'b0;
            step($sformatf("vec%0d", i), vecs[i].exp);
        end
        idle();
        check_cnt("table");
        check("table_halted", 32'(halted), 32'd0);

        // Memory wait: busy for 4 cycles, released in the 5th
        mem_en = 1'b1; mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) step($sformatf("memwait%0d", i), OMem);
        mem_busy = 1'b0;
        step("memwait_release", ONone);
        idle();
        check_cnt("memwait");
        // Back in RUN: load-use must act again
        id_rs = 3'd3; id_rs_used = 1'b1; ex_rd = 3'd3; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
        step("run_after_wait", OLoad);
        idle();
        check_cnt("run_after_wait");

        // Timeout: RUN entry cycle plus 15 MEMWAIT cycles
        mem_en = 1'b1; mem_busy = 1'b1;
        step("to_entry", OMem);
        for (int i = 1; i <= 15; i++) begin
            check($sformatf("to_noerr%0d", i), 32'(timeout_err), 32'd0);
            check($sformatf("to_nohalt%0d", i), 32'(halted), 32'd0);
            step($sformatf("to_wait%0d", i), OMem);
        end
        check("to_err", 32'(timeout_err), 32'd1);
        check("to_halted", 32'(halted), 32'd1);
        check_cnt("to_enter");
        idle();
        br_taken = 1'b1;
        step("halt_ignores_br", OHalt);
        idle();
        step("halt_hold", OHalt);
        check("to_err_sticky", 32'(timeout_err), 32'd1);
        check("to_halted_sticky", 32'(halted), 32'd1);
        check_cnt("halt");

        // Reset mid-wait, asynchronous
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_cnt = 0;
        mem_en = 1'b1; mem_busy = 1'b1;
        step("rw_entry", OMem);
        step("rw_wait", OMem);
        #2;
        rst = 1'b0;
        #1;
        check("rw_outs", 32'(outs), 32'(ONone));
        check("rw_halted", 32'(halted), 32'd0);
        check("rw_timeout", 32'(timeout_err), 32'd0);
        exp_cnt = 0;
        check_cnt("rw");
        @(negedge clk);
        idle();
        rst = 1'b1;
        step("rw_after", ONone);

        // Exception together with memory busy: HALT, not MEMWAIT
        excp = 1'b1; mem_en = 1'b1; mem_busy = 1'b1;
        step("excp_cycle", OExcp);
        idle();
        check("excp_halted", 32'(halted), 32'd1);
        check("excp_timeout", 32'(timeout_err), 32'd0);
        step("excp_halt", OHalt);
        check_cnt("excp");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
